// File: rtl/dma_copy_if.sv
// Control and memory-master signal bundle for dma_copy_engine.
// master = engine side, slave = requester plus data memory side.
interface dma_copy_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 16
);
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] fill_val;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  words_done;
  logic [ADDR_W-1:0] read_addr;
  logic [DATA_W-1:0] read;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] data;
  logic              WE;

  modport master (
    input  start, mode, src_addr, dst_addr, len, fill_val, read,
    output busy, done, words_done, read_addr, write_addr, data, WE
  );

  modport slave (
    output start, mode, src_addr, dst_addr, len, fill_val, read,
    input  busy, done, words_done, read_addr, write_addr, data, WE
  );
endinterface

// File: rtl/dma_copy_engine.sv
// Word-at-a-time memory copy/fill engine driving a combinational-read,
// synchronous-write memory port. Copy takes RD+WR per word, fill takes WR only.
module dma_copy_engine #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input logic        clk,
  input logic        rst,
  dma_copy_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [LEN_W-1:0]  words_q, words_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] buf_q, buf_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      remain_q  <= '0;
      words_q   <= '0;
      mode_q    <= 1'b0;
      fill_q    <= '0;
      buf_q     <= '0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      remain_q  <= remain_d;
      words_q   <= words_d;
      mode_q    <= mode_d;
      fill_q    <= fill_d;
      buf_q     <= buf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    remain_d  = remain_q;
    words_d   = words_q;
    mode_d    = mode_q;
    fill_d    = fill_q;
    buf_d     = buf_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          src_ptr_d = bus.src_addr;
          dst_ptr_d = bus.dst_addr;
          remain_d  = bus.len;
          mode_d    = bus.mode;
          fill_d    = bus.fill_val;
          words_d   = '0;
          if (bus.len == '0) begin
            state_d = StDone;
          end else if (bus.mode) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: begin
        buf_d   = bus.read;
        state_d = StWr;
      end
      StWr: begin
        // Pointers wrap naturally at the address width.
        dst_ptr_d = dst_ptr_q + ADDR_W'(1);
        if (!mode_q) begin
          src_ptr_d = src_ptr_q + ADDR_W'(1);
        end
        words_d  = words_q + LEN_W'(1);
        remain_d = remain_q - LEN_W'(1);
        if (remain_q == LEN_W'(1)) begin
          state_d = StDone;
        end else if (mode_q) begin
          state_d = StWr;
        end else begin
          state_d = StRd;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign bus.busy       = (state_q == StRd) || (state_q == StWr);
  assign bus.done       = (state_q == StDone);
  assign bus.WE         = (state_q == StWr);
  assign bus.words_done = words_q;
  assign bus.read_addr  = src_ptr_q;
  assign bus.write_addr = dst_ptr_q;
  assign bus.data       = ((state_q == StWr) && mode_q) ? fill_q : buf_q;

endmodule

// File: tb/tb_dma_copy_engine.sv
// Bench for dma_copy_engine: directed table, hand-written corner sequences and
// randomized transfers checked against an array-level copy/fill model.
module tb_dma_copy_engine;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 16;
  localparam int          MEM_N  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dma_copy_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  dma_copy_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DATA_W-1:0] mem     [MEM_N];
  logic [DATA_W-1:0] ref_mem [MEM_N];
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [DATA_W-1:0] pl_data = '0;

  assign bus.read = mem[bus.read_addr];
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.WE) mem[bus.write_addr] <= bus.data;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[a] = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Reference: transfer as a plain ascending array loop.
  task automatic ref_xfer(input logic m, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                          input int n, input logic [DATA_W-1:0] f,
                          output logic [DATA_W-1:0] last);
    logic [ADDR_W-1:0] sa, da;
    last = '0;
    for (int i = 0; i < n; i++) begin
      sa = ADDR_W'(32'(s) + 32'(i));
      da = ADDR_W'(32'(d) + 32'(i));
      if (m) ref_mem[da] = f;
      else begin
        last = ref_mem[sa];
        ref_mem[da] = last;
      end
    end
  endtask

  task automatic cmp_mem(input string name);
    int bad = 0;
    for (int i = 0; i < MEM_N; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk({name, " mismatched words"}, 64'(bad), 64'(0));
  endtask

  task automatic scramble(input logic st);
    bus.start    = st;
    bus.mode     = 1'($urandom);
    bus.src_addr = ADDR_W'($urandom);
    bus.dst_addr = ADDR_W'($urandom);
    bus.len      = LEN_W'($urandom);
    bus.fill_val = $urandom;
  endtask

  task automatic run_xfer(input logic m, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                          input logic [LEN_W-1:0] n, input logic [DATA_W-1:0] f,
                          input int exp_lat, input bit poke, input string tag);
    int cyc, busy_c, we_c;
    bit seen;
    logic [DATA_W-1:0] last;
    ref_xfer(m, s, d, int'(n), f, last);
    @(negedge clk);
    bus.start = 1'b1; bus.mode = m; bus.src_addr = s; bus.dst_addr = d;
    bus.len = n; bus.fill_val = f;
    @(posedge clk);
    #1 scramble(poke);
    chk({tag, " words_done cleared"}, 64'(bus.words_done), 64'(0));
    cyc = 1; seen = 0; busy_c = 0; we_c = 0;
    while (cyc <= exp_lat + 20) begin
      if (bus.busy) busy_c++;
      if (bus.WE) we_c++;
      if (bus.done) begin
        seen = 1;
        break;
      end
      if (poke) scramble(1'b1);
      @(posedge clk);
      #1 cyc++;
    end
    bus.start = 1'b0;
    chk({tag, " latency"}, seen ? 64'(cyc) : 64'(0), 64'(exp_lat));
    chk({tag, " busy cycles"}, 64'(busy_c), 64'(exp_lat - 1));
    chk({tag, " WE cycles"}, 64'(we_c), 64'(n));
    chk({tag, " words_done at done"}, 64'(bus.words_done), 64'(n));
    @(posedge clk);
    #1 chk({tag, " done/busy/WE after done"}, 64'({bus.done, bus.busy, bus.WE}), 64'(0));
    repeat (2) @(posedge clk);
    #1 chk({tag, " words_done held"}, 64'(bus.words_done), 64'(n));
    chk({tag, " idle read_addr"}, 64'(bus.read_addr),
        m ? 64'(s) : 64'(ADDR_W'(32'(s) + 32'(n))));
    chk({tag, " idle write_addr"}, 64'(bus.write_addr), 64'(ADDR_W'(32'(d) + 32'(n))));
    if (!m && n != 0) chk({tag, " idle data=buffer"}, 64'(bus.data), 64'(last));
    cmp_mem(tag);
  endtask

  typedef struct {
    logic              m;
    logic [ADDR_W-1:0] s;
    logic [ADDR_W-1:0] d;
    logic [LEN_W-1:0]  n;
    logic [DATA_W-1:0] f;
    int                lat;
    string             tag;
  } vec_t;

  initial begin : main
    vec_t vecs[4];
    logic [DATA_W-1:0] pat[6];
    logic [DATA_W-1:0] dummy;
    logic              m;
    logic [ADDR_W-1:0] s, d;
    logic [LEN_W-1:0]  n;
    int                lat;

    vecs[0] = '{1'b0, 15'd3, 15'd20, 16'd6, 32'h0, 13, "copy"};
    vecs[1] = '{1'b1, 15'd0, 15'd10, 16'd4, 32'hDEADBEEF, 5, "fill"};
    vecs[2] = '{1'b0, 15'd50, 15'd60, 16'd0, 32'h0, 1, "len0"};
    vecs[3] = '{1'b1, 15'd0, 15'h7FFE, 16'd3, 32'hCAFEF00D, 4, "wrap"};
    pat = '{32'd5, 32'd47, 32'd5, 32'd0, 32'd55, 32'd1};

    for (int i = 0; i < MEM_N; i++) ref_mem[i] = '0;
    scramble(1'b0);
    bus.start = 1'b0;

    // Asynchronous reset, checked before any clock edge.
    #3 rst = 1'b1;
    #1;
    chk("reset busy/done/WE", 64'({bus.busy, bus.done, bus.WE}), 64'(0));
    chk("reset words_done", 64'(bus.words_done), 64'(0));
    chk("reset addrs", 64'({bus.read_addr, bus.write_addr}), 64'(0));
    chk("reset data", 64'(bus.data), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 512; i++) preload(ADDR_W'(i), $urandom);
    for (int i = MEM_N - 40; i < MEM_N; i++) preload(ADDR_W'(i), $urandom);
    for (int i = 0; i < 6; i++) preload(ADDR_W'(3 + i), pat[i]);

    for (int v = 0; v < 4; v++)
      run_xfer(vecs[v].m, vecs[v].s, vecs[v].d, vecs[v].n, vecs[v].f, vecs[v].lat, 1'b0,
               vecs[v].tag);
    for (int i = 0; i < 6; i++) chk("copy dest word", 64'(mem[20 + i]), 64'(pat[i]));
    for (int i = 0; i < 4; i++) chk("fill dest word", 64'(mem[10 + i]), 64'(32'hDEADBEEF));
    chk("wrap 7FFE", 64'(mem[32'h7FFE]), 64'(32'hCAFEF00D));
    chk("wrap 7FFF", 64'(mem[32'h7FFF]), 64'(32'hCAFEF00D));
    chk("wrap 0000", 64'(mem[0]), 64'(32'hCAFEF00D));

    // start held high with junk requests throughout a copy
    run_xfer(1'b0, 15'd300, 15'd400, 16'd5, 32'h0, 11, 1'b1, "ignore_start");

    // Reset after two words of a six-word copy.
    ref_xfer(1'b0, 15'd100, 15'd200, 2, 32'h0, dummy);
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 1'b0; bus.src_addr = 15'd100; bus.dst_addr = 15'd200;
    bus.len = 16'd6;
    @(posedge clk);
    #1 scramble(1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midreset busy/WE/done", 64'({bus.busy, bus.WE, bus.done}), 64'(0));
    chk("midreset words_done", 64'(bus.words_done), 64'(0));
    chk("midreset addrs/data", 64'({bus.read_addr, bus.write_addr} | 30'(bus.data)), 64'(0));
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    cmp_mem("midreset partial");
    run_xfer(1'b0, 15'd100, 15'd200, 16'd6, 32'h0, 13, 1'b0, "after_reset");

    for (int t = 0; t < 20; t++) begin
      m = 1'($urandom_range(0, 1));
      n = LEN_W'($urandom_range(0, 40));
      s = ($urandom_range(0, 3) == 0) ? ADDR_W'(MEM_N - int'($urandom_range(1, 30)))
                                      : ADDR_W'($urandom_range(0, 400));
      case ($urandom_range(0, 3))
        0: d = s;
        1: d = ADDR_W'(32'(s) + $urandom_range(1, 8));
        2: d = ADDR_W'($urandom_range(0, 450));
        default: d = ADDR_W'(MEM_N - int'($urandom_range(1, 30)));
      endcase
      lat = (n == 0) ? 1 : (m ? int'(n) + 1 : 2 * int'(n) + 1);
      run_xfer(m, s, d, n, $urandom, lat, 1'($urandom_range(0, 1)), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dma_copy_engine.md
DMA_COPY_ENGINE -- requirements
Module: dma_copy_engine

Interface
REQ-001 Parameter ADDR_W, default 15, word-address width of the data memory port.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter LEN_W, default 16, transfer-length width (must exceed ADDR_W so a full 2^ADDR_W-word transfer is expressible).
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset, with ports named as below:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
REQ-005 Control ports:
- start     input   1       one-cycle request, sampled only in IDLE
- mode      input   1       0 = copy, 1 = fill
- src_addr  input   ADDR_W  copy source base word address
- dst_addr  input   ADDR_W  destination base word address
- len       input   LEN_W   word count
- fill_val  input   DATA_W  fill pattern
- busy      output  1       transfer in progress
- done      output  1       one-cycle completion pulse
- words_done output LEN_W   words written in the current or last transfer
REQ-006 Memory master ports, matching the data memory's combinational-read / synchronous-write port:
- read_addr   output  ADDR_W  memory read address
- read        input   DATA_W  memory read data, valid in the same cycle
- write_addr  output  ADDR_W  memory write address
- data        output  DATA_W  memory write data
- WE          output  1       write enable, sampled by memory at posedge clk

Function
REQ-007 The FSM SHALL have states IDLE, RD, WR and DONE.
REQ-008 In IDLE with start=1 at a clock edge, the block SHALL latch src_addr, dst_addr, len, mode and fill_val into internal registers, and clear words_done.
- len=0: go to DONE.
- mode=0: go to RD.
- mode=1: go to WR.
REQ-009 In IDLE with start=0, the block SHALL remain in IDLE.
REQ-010 RD SHALL drive read_addr=src_ptr, capture read into the buffer register at the edge, and go to WR.
REQ-011 WR SHALL assert WE=1 and drive write_addr=dst_ptr. data SHALL be the buffer in copy mode and the latched fill_val in fill mode.
REQ-012 At the WR edge, the block SHALL:
- increment dst_ptr, and src_ptr in copy mode;
- increment words_done and decrement the remaining count;
- if the remaining count was 1, go to DONE; otherwise go to RD (copy) or stay in WR (fill).
REQ-013 Pointers SHALL increment modulo 2^ADDR_W, so that address 0x7FFF wraps to 0x0000 with no error.
REQ-014 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE unconditionally.
REQ-015 busy SHALL be 1 exactly in RD and WR.
REQ-016 WE SHALL be 1 only in WR.
REQ-017 Latency from the start edge to the done cycle SHALL be:
- copy: 2*len+1 cycles;
- fill: len+1 cycles;
- len=0: 1 cycle.
REQ-018 start asserted in RD, WR or DONE SHALL be ignored and have no effect.
REQ-019 Changes to the request inputs after the start edge SHALL have no effect on a transfer in progress.
REQ-020 Copy SHALL proceed in ascending address order.
- If src_addr < dst_addr < src_addr+len, the words already written SHALL be re-read, which propagates the leading pattern (defined behaviour, not an error).
- If src_addr = dst_addr, the copy SHALL rewrite identical values.
REQ-021 words_done SHALL hold its final value after DONE until the next accepted start.
REQ-022 In IDLE and DONE:
- read_addr SHALL equal src_ptr;
- write_addr SHALL equal dst_ptr;
- data SHALL equal the buffer;
- WE SHALL be 0.

Reset
REQ-023 rst=1 SHALL immediately, without waiting for a clock edge:
- force state IDLE;
- set busy, done, WE, words_done, read_addr, write_addr, data and all internal registers to 0.
REQ-024 Reset asserted mid-transfer SHALL abort the transfer with no further writes; words already written SHALL remain in memory.

Verification
REQ-025 The bench SHALL cover at least these directed scenarios:
- Copy: memory[3..8] = {5, 47, 5, 0, 55, 1}; start mode=0 src=3 dst=20 len=6 -> memory[20..25] = {5, 47, 5, 0, 55, 1}; done exactly 13 cycles after the start edge; words_done=6; busy high for 12 cycles.
- Fill: mode=1 dst=10 len=4 fill_val=0xDEADBEEF -> memory[10..13] = 0xDEADBEEF; WE high for 4 consecutive cycles; done at cycle 5.
- len=0 -> done pulse 1 cycle after the start edge; WE never asserted; words_done=0.
- Wrap: fill dst=0x7FFE len=3 -> writes at 0x7FFE, 0x7FFF and 0x0000.
- Start ignored while busy: a second start with different src/dst during a copy -> the original transfer completes unchanged and no extra transfer runs.
- Reset mid-transfer: rst asserted after 2 words of a len=6 copy -> busy=0 and WE=0 immediately; memory holds 2 words; a new start afterwards completes normally.
